// File: rtl/node_integrator.sv
// rtl/node_integrator.sv - soft-body node integrator: damped velocity/position update, one node per cycle
//
// Purpose:
//   Integrates one timestep for NUM_NODES 2-D nodes. input_valid in IDLE snapshots
//   the inputs. UPDATE then processes one node (both axes) per cycle. RESULT is
//   followed by a one-cycle output_valid pulse.
//   Per axis:
//     a     = F >>> DT_SHIFT
//     vd    = v - (v >>> DAMP_SHIFT)
//     v_new = sat_V(vd + a)
//     p_new = sat_P(p + (v_new >>> DT_SHIFT))
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-high reset
//   input_valid     one-cycle request; honoured only in IDLE
//   forces          [axis][node] summed force, axis 0 = x, axis 1 = y
//   nodes_in        [axis][node] current positions
//   velocities_in   [axis][node] current velocities
//   nodes_out       [axis][node] updated positions; held while idle
//   velocities_out  [axis][node] updated velocities; held while idle
//   busy            high whenever the FSM is not in IDLE
//   output_valid    one-cycle pulse; the output arrays are complete

module node_integrator #(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int DT_SHIFT      = 2,
    parameter int DAMP_SHIFT    = 3
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            input_valid,
    input  logic signed [FORCE_SIZE-1:0]    forces         [1:0][NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] nodes_in       [1:0][NUM_NODES],
    input  logic signed [VELOCITY_SIZE-1:0] velocities_in  [1:0][NUM_NODES],
    output logic signed [POSITION_SIZE-1:0] nodes_out      [1:0][NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] velocities_out [1:0][NUM_NODES],
    output logic                            busy,
    output logic                            output_valid
);

    localparam int MAXW = (POSITION_SIZE > VELOCITY_SIZE)
                        ? ((POSITION_SIZE > FORCE_SIZE) ? POSITION_SIZE : FORCE_SIZE)
                        : ((VELOCITY_SIZE > FORCE_SIZE) ? VELOCITY_SIZE : FORCE_SIZE);
    // Three guard bits: vd + a and p + v_new/dt can each grow by one bit
    // beyond the widest operand, so nothing wraps before saturation.
    localparam int EW = MAXW + 3;
    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_NODES - 1);
    localparam logic signed [EW-1:0] V_MAX    = EW'((1 << (VELOCITY_SIZE - 1)) - 1);
    localparam logic signed [EW-1:0] V_MIN    = EW'(-(1 << (VELOCITY_SIZE - 1)));
    localparam logic signed [EW-1:0] P_MAX    = EW'((1 << (POSITION_SIZE - 1)) - 1);
    localparam logic signed [EW-1:0] P_MIN    = EW'(-(1 << (POSITION_SIZE - 1)));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx_q;

    logic signed [FORCE_SIZE-1:0]    snap_f [1:0][NUM_NODES];
    logic signed [POSITION_SIZE-1:0] snap_p [1:0][NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] snap_v [1:0][NUM_NODES];

    logic signed [POSITION_SIZE-1:0] p_new [2];
    logic signed [VELOCITY_SIZE-1:0] v_new [2];

    logic signed [EW-1:0] f_e;
    logic signed [EW-1:0] v_e;
    logic signed [EW-1:0] p_e;
    logic signed [EW-1:0] vs_e;
    logic signed [EW-1:0] vn_e;
    logic signed [EW-1:0] ps_e;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (input_valid) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // Per-axis datapath for the node currently selected by idx_q
    always_comb begin
        f_e      = '0;
        v_e      = '0;
        p_e      = '0;
        vs_e     = '0;
        vn_e     = '0;
        ps_e     = '0;
        p_new[0] = '0;
        p_new[1] = '0;
        v_new[0] = '0;
        v_new[1] = '0;

        for (int ax = 0; ax < 2; ax++) begin
            // Size casts of signed operands sign-extend into the wide domain.
            f_e  = EW'(snap_f[ax][idx_q]);
            v_e  = EW'(snap_v[ax][idx_q]);
            p_e  = EW'(snap_p[ax][idx_q]);
            vs_e = (v_e - (v_e >>> DAMP_SHIFT)) + (f_e >>> DT_SHIFT);

            if (vs_e > V_MAX) begin
                v_new[ax] = V_MAX[VELOCITY_SIZE-1:0];
            end else if (vs_e < V_MIN) begin
                v_new[ax] = V_MIN[VELOCITY_SIZE-1:0];
            end else begin
                v_new[ax] = vs_e[VELOCITY_SIZE-1:0];
            end

            // The position uses the saturated new velocity, not the raw sum.
            vn_e = EW'(v_new[ax]);
            ps_e = p_e + (vn_e >>> DT_SHIFT);

            if (ps_e > P_MAX) begin
                p_new[ax] = P_MAX[POSITION_SIZE-1:0];
            end else if (ps_e < P_MIN) begin
                p_new[ax] = P_MIN[POSITION_SIZE-1:0];
            end else begin
                p_new[ax] = ps_e[POSITION_SIZE-1:0];
            end
        end
    end

    // Snapshot, index, output arrays and the registered completion pulse
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_q        <= '0;
            output_valid <= 1'b0;
            for (int ax = 0; ax < 2; ax++) begin
                for (int n = 0; n < NUM_NODES; n++) begin
                    snap_f[ax][n]         <= '0;
                    snap_p[ax][n]         <= '0;
                    snap_v[ax][n]         <= '0;
                    nodes_out[ax][n]      <= '0;
                    velocities_out[ax][n] <= '0;
                end
            end
        end else begin
            // The pulse is raised on the edge that leaves RESULT, so a reset
            // that arrives while in UPDATE or RESULT never produces it.
            output_valid <= (state_q == RESULT);
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (input_valid) begin
                        snap_f <= forces;
                        snap_p <= nodes_in;
                        snap_v <= velocities_in;
                    end
                end
                UPDATE: begin
                    nodes_out[0][idx_q]      <= p_new[0];
                    nodes_out[1][idx_q]      <= p_new[1];
                    velocities_out[0][idx_q] <= v_new[0];
                    velocities_out[1][idx_q] <= v_new[1];
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_integrator.sv
// tb/tb_node_integrator.sv - self-checking bench for node_integrator

module tb_node_integrator;

    localparam int N   = 10;
    localparam int PW  = 8;
    localparam int VW  = 8;
    localparam int FW  = 8;
    localparam int DT  = 2;
    localparam int DMP = 3;

    logic clk_in = 1'b0;
    logic rst_in;
    logic input_valid;
    logic signed [FW-1:0] forces         [1:0][N];
    logic signed [PW-1:0] nodes_in       [1:0][N];
    logic signed [VW-1:0] velocities_in  [1:0][N];
    logic signed [PW-1:0] nodes_out      [1:0][N];
    logic signed [VW-1:0] velocities_out [1:0][N];
    logic busy;
    logic output_valid;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int exp_p [2][N];
    int exp_v [2][N];

    node_integrator #(
        .NUM_NODES    (N),
        .POSITION_SIZE(PW),
        .VELOCITY_SIZE(VW),
        .FORCE_SIZE   (FW),
        .DT_SHIFT     (DT),
        .DAMP_SHIFT   (DMP)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .input_valid   (input_valid),
        .forces        (forces),
        .nodes_in      (nodes_in),
        .velocities_in (velocities_in),
        .nodes_out     (nodes_out),
        .velocities_out(velocities_out),
        .busy          (busy),
        .output_valid  (output_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    function automatic int clamp(input int x, input int w);
        int lo;
        int hi;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Reference step on plain integers; computes the whole array at once.
    task automatic model_step();
        int f;
        int v;
        int p;
        int vn;
        for (int ax = 0; ax < 2; ax++) begin
            for (int n = 0; n < N; n++) begin
                f  = forces[ax][n];
                v  = velocities_in[ax][n];
                p  = nodes_in[ax][n];
                vn = clamp(v - (v >>> DMP) + (f >>> DT), VW);
                exp_v[ax][n] = vn;
                exp_p[ax][n] = clamp(p + (vn >>> DT), PW);
            end
        end
    endtask

    task automatic set_vec(input int kind);
        int p;
        int v;
        int f;
        for (int ax = 0; ax < 2; ax++) begin
            for (int n = 0; n < N; n++) begin
                case (kind)
                    0: begin p = 10; v = 0; f = 0; end
                    1: begin p = n * 7 - 30 + ax * 5; v = n * 3 - 10 - ax; f = 20 - n * 9 + ax * 4; end
                    2: begin p = 40 - n * 11; v = (n % 4) * 20 - 30; f = n * 13 - 60; end
                    default: begin p = -5; v = 50; f = 100; end
                endcase
                if (kind == 1) begin
                    if (n == 3) begin p = 0; v = 0; f = (ax == 0) ? 16 : -16; end
                    if (n == 4 && ax == 0) begin p = 0; v = -8; f = 0; end
                    if (n == 5 && ax == 0) begin p = 120; v = 127; f = 127; end
                    if (n == 6 && ax == 0) begin p = -128; v = -128; f = -128; end
                end
                nodes_in[ax][n]      = PW'(p);
                velocities_in[ax][n] = VW'(v);
                forces[ax][n]        = FW'(f);
            end
        end
    endtask

    // Compare process: every completion pulse must match the model.
    always @(negedge clk_in) begin
        if (!rst_in && output_valid) begin
            pulses++;
            for (int ax = 0; ax < 2; ax++) begin
                for (int n = 0; n < N; n++) begin
                    chk($sformatf("p_out[%0d][%0d]", ax, n), nodes_out[ax][n], exp_p[ax][n]);
                    chk($sformatf("v_out[%0d][%0d]", ax, n), velocities_out[ax][n], exp_v[ax][n]);
                end
            end
        end
    end

    task automatic do_req(input bit repulse);
        int lat;
        bit seen;
        chk("idle_before_accept", busy, 0);
        model_step();
        exp_pulses++;
        input_valid = 1'b1;
        @(posedge clk_in);
        #1 input_valid = 1'b0;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 3 * N) begin
            @(negedge clk_in);
            lat++;
            if (repulse && lat == 3) begin
                set_vec(3);
                input_valid = 1'b1;
            end else begin
                input_valid = 1'b0;
            end
            if (output_valid) seen = 1;
            else chk("busy_in_step", busy, 1);
        end
        chk("latency", lat, N + 2);
        chk("busy_at_valid", busy, 0);
        #1;
    endtask

    initial begin
        int p0;
        rst_in      = 1'b1;
        input_valid = 1'b0;
        set_vec(0);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", output_valid, 0);
        chk("rst_p_out", nodes_out[1][9], 0);
        chk("rst_v_out", velocities_out[0][0], 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        set_vec(0);
        do_req(0);
        chk("all10_p", nodes_out[0][0], 10);
        chk("all10_v", velocities_out[1][9], 0);

        set_vec(1);
        do_req(0);
        repeat (3) @(negedge clk_in);
        chk("n3x_v", velocities_out[0][3], 4);
        chk("n3x_p", nodes_out[0][3], 1);
        chk("n3y_v", velocities_out[1][3], -4);
        chk("n3y_p", nodes_out[1][3], -1);
        chk("damp_v", velocities_out[0][4], -7);
        chk("damp_p", nodes_out[0][4], -2);
        chk("satpos_v", velocities_out[0][5], 127);
        chk("satpos_p", nodes_out[0][5], 127);
        chk("satneg_v", velocities_out[0][6], -128);
        chk("satneg_p", nodes_out[0][6], -128);

        set_vec(2);
        do_req(1);
        repeat (4) @(negedge clk_in);
        chk("no_extra_pulse", pulses, exp_pulses);

        set_vec(1);
        input_valid = 1'b1;
        @(posedge clk_in);
        #1 input_valid = 1'b0;
        repeat (4) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", output_valid, 0);
        chk("abort_p0", nodes_out[0][0], 0);
        chk("abort_v1", velocities_out[1][1], 0);
        chk("abort_p5", nodes_out[0][5], 0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        p0 = pulses;
        repeat (N + 5) @(negedge clk_in);
        chk("no_valid_after_abort", pulses, p0);

        set_vec(1);
        do_req(0);
        chk("post_rst_n3x_p", nodes_out[0][3], 1);
        chk("post_rst_satneg_p", nodes_out[0][6], -128);
        repeat (3) @(negedge clk_in);
        chk("pulse_count", pulses, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/node_integrator.md
NODE_INTEGRATOR -- requirements
Module: node_integrator

Interface
REQ-001 SHALL expose parameter NUM_NODES, default 10: number of soft-body nodes.
REQ-002 SHALL expose parameter POSITION_SIZE, default 8: signed position width.
REQ-003 SHALL expose parameter VELOCITY_SIZE, default 8: signed velocity width.
REQ-004 SHALL expose parameter FORCE_SIZE, default 8: signed force width.
REQ-005 SHALL expose parameter DT_SHIFT, default 2: timestep as right-shift amount.
REQ-006 SHALL expose parameter DAMP_SHIFT, default 3: per-step velocity damping as v >>> DAMP_SHIFT.
REQ-007 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_in  input  1  asynchronous, active-high reset.
REQ-009 input_valid  input  1  one-cycle request to integrate one timestep.
REQ-010 forces  input  signed [FORCE_SIZE-1:0] [1:0][NUM_NODES]  summed per-node force (x=index 0, y=index 1), e.g. ideal-shape plus spring forces.
REQ-011 nodes_in  input  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  current positions.
REQ-012 velocities_in  input  signed [VELOCITY_SIZE-1:0] [1:0][NUM_NODES]  current velocities.
REQ-013 nodes_out  output  signed [POSITION_SIZE-1:0] [1:0][NUM_NODES]  updated positions.
REQ-014 velocities_out  output  signed [VELOCITY_SIZE-1:0] [1:0][NUM_NODES]  updated velocities.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 output_valid  output  1  one-cycle pulse: nodes_out/velocities_out complete.

Function
REQ-017 SHALL implement states IDLE, UPDATE, RESULT.
REQ-018 IDLE: on input_valid, SHALL snapshot forces, nodes_in, velocities_in into internal registers, set index to 0, go to UPDATE.
REQ-019 UPDATE: SHALL process exactly one node (both axes) per cycle from the snapshot, writing nodes_out/velocities_out for that index.
REQ-020 UPDATE: after index NUM_NODES-1 is written SHALL go to RESULT; index SHALL never exceed NUM_NODES-1.
REQ-021 RESULT: SHALL set output_valid for exactly one cycle and return to IDLE.
REQ-022 Latency: output_valid SHALL be high in the cycle following edge NUM_NODES+1, counting the accepting edge as edge 0.
REQ-023 Per axis: a = F >>> DT_SHIFT (arithmetic); vd = v - (v >>> DAMP_SHIFT); v_new = sat_V(vd + a); p_new = sat_P(p + (v_new >>> DT_SHIFT)).
REQ-024 Intermediate sums SHALL be computed at least 2 bits wider than the widest operand; no intermediate wraps.
REQ-025 sat_V/sat_P SHALL clamp to [-2^(W-1), 2^(W-1)-1] of VELOCITY_SIZE/POSITION_SIZE respectively.
REQ-026 input_valid in UPDATE or RESULT SHALL be ignored, not queued; snapshot SHALL NOT change.
REQ-027 Input changes after acceptance SHALL NOT affect the current computation.
REQ-028 Output arrays SHALL hold their last values in IDLE; entries for not-yet-processed indices during UPDATE are unspecified to the consumer and SHALL be sampled only on output_valid.
REQ-029 A new request SHALL be accepted in the first IDLE cycle after RESULT (back-to-back throughput NUM_NODES+2 cycles).

Reset
REQ-030 rst_in high SHALL immediately force state IDLE, index 0, output_valid 0, busy 0, all nodes_out/velocities_out and snapshot registers 0, independent of clk_in.
REQ-031 Reset during UPDATE or RESULT SHALL abort the step; no output_valid pulse SHALL follow for that request.
REQ-032 After rst_in deasserts, first input_valid SHALL be accepted normally.

Verification
REQ-033 All nodes p=10, v=0, F=0 -> output_valid at edge NUM_NODES+2, all p_out=10, v_out=0.
REQ-034 Node 3 x: p=0, v=0, F=16 -> v_out=4, p_out=1; y: F=-16 -> v_out=-4, p_out=-1.
REQ-035 Damping: v=-8, F=0, p=0 -> v_out=-7, p_out=-2.
REQ-036 Saturation: v=127, F=127, p=120 -> v_out=127, p_out=127; v=-128, F=-128, p=-128 -> v_out=-128, p_out=-128.
REQ-037 input_valid re-pulsed at cycle 3 of UPDATE with different data -> ignored; results match first snapshot; exactly one output_valid pulse.
REQ-038 rst_in asserted mid-UPDATE asynchronously -> outputs 0, busy 0 immediately; no output_valid; next request completes with correct values.
